// File: rtl/distributed_fifo_shift_lvl_pkg.sv
// Shared types and helpers for the level-tracking shift FIFO.
package distributed_fifo_shift_lvl_pkg;

    // Per-cycle action applied to the occupancy counter.
    typedef enum logic [1:0] {
        LvlHold,
        LvlInc,
        LvlDec,
        LvlClr
    } lvl_op_e;

    // A threshold is usable when it lies within 0..depth.
    function automatic bit thresh_ok(int unsigned depth, int unsigned num);
        return num <= depth;
    endfunction

endpackage

// File: rtl/distributed_fifo_shift_lvl_if.sv
// Stream, control and status bundle of the level-tracking shift FIFO.
interface distributed_fifo_shift_lvl_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned AWIDTH = 5
);
    logic              fi_stb;
    logic [WIDTH-1:0]  fi_dat;
    logic              fi_flush;
    logic              fi_err_clr;
    logic              fi_busy;
    logic              fi_full;
    logic              fi_aempty;
    logic              fi_empty;
    logic [AWIDTH:0]   fi_level;
    logic              fi_err_ovf;
    logic              fi_err_udf;
    logic              fo_stb;
    logic              fo_ack;
    logic [WIDTH-1:0]  fo_dat;

    // Producer/consumer side.
    modport master (
        output fi_stb, fi_dat, fi_flush, fi_err_clr, fo_ack,
        input  fi_busy, fi_full, fi_aempty, fi_empty, fi_level,
        input  fi_err_ovf, fi_err_udf, fo_stb, fo_dat
    );

    // FIFO side.
    modport slave (
        input  fi_stb, fi_dat, fi_flush, fi_err_clr, fo_ack,
        output fi_busy, fi_full, fi_aempty, fi_empty, fi_level,
        output fi_err_ovf, fi_err_udf, fo_stb, fo_dat
    );
endinterface

// File: rtl/distributed_fifo_shift_lvl.sv
// Shift-register FIFO with exact occupancy, almost-full/empty thresholds,
// synchronous flush and sticky overflow/underflow flags.
module distributed_fifo_shift_lvl
    import distributed_fifo_shift_lvl_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned AWIDTH     = 5,
    parameter int unsigned BUSY_NUM   = 6,
    parameter int unsigned AEMPTY_NUM = 2
) (
    input logic                          fi_clk,
    input logic                          fi_rst_n,
    distributed_fifo_shift_lvl_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** AWIDTH;
    localparam logic [AWIDTH:0] LvlFull  = (AWIDTH + 1)'(DEPTH);
    localparam logic [AWIDTH:0] BusyThr  = (AWIDTH + 1)'(DEPTH - BUSY_NUM);
    localparam logic [AWIDTH:0] AemptyThr = (AWIDTH + 1)'(AEMPTY_NUM);

    // Out-of-range thresholds would make the status decodes meaningless.
    if (!thresh_ok(DEPTH, BUSY_NUM) || !thresh_ok(DEPTH, AEMPTY_NUM)) begin : g_bad_thresh
        $error("BUSY_NUM and AEMPTY_NUM must lie within 0..DEPTH");
    end

    logic [WIDTH-1:0]  r_sh [DEPTH];
    logic [AWIDTH:0]   r_level;
    logic [AWIDTH:0]   w_level_nxt;
    logic              r_err_ovf;
    logic              r_err_udf;
    logic [AWIDTH-1:0] w_rd_idx;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_set_ovf;
    logic              w_set_udf;
    lvl_op_e           w_op;

    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == LvlFull);
    assign w_pop     = bus.fo_ack & ~w_empty;
    // Pushing into a full FIFO is fine when the same cycle pops a word out.
    assign w_push    = bus.fi_stb & (~w_full | w_pop);
    assign w_set_ovf = bus.fi_stb & w_full & ~w_pop & ~bus.fi_flush;
    assign w_set_udf = bus.fo_ack & w_empty & ~bus.fi_flush;

    // Shift array: new word enters at sh[0], oldest sits at sh[level-1].
    always_ff @(posedge fi_clk) begin
        if (w_push) begin
            r_sh[0] <= bus.fi_dat;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_sh[i] <= r_sh[i-1];
            end
        end
    end

    // Decode the counter action; flush overrides any push/pop.
    always_comb begin
        w_op = LvlHold;
        if (bus.fi_flush) begin
            w_op = LvlClr;
        end else if (w_push && !w_pop) begin
            w_op = LvlInc;
        end else if (w_pop && !w_push) begin
            w_op = LvlDec;
        end
    end

    // Next occupancy from the decoded action.
    always_comb begin
        w_level_nxt = r_level;
        unique case (w_op)
            LvlInc:  w_level_nxt = r_level + 1'b1;
            LvlDec:  w_level_nxt = r_level - 1'b1;
            LvlClr:  w_level_nxt = '0;
            default: w_level_nxt = r_level;
        endcase
    end

    // Occupancy and sticky error flags; a set in the clear cycle wins.
    always_ff @(posedge fi_clk) begin
        if (!fi_rst_n) begin
            r_level   <= '0;
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else begin
            r_level   <= w_level_nxt;
            r_err_ovf <= w_set_ovf | (r_err_ovf & ~bus.fi_err_clr);
            r_err_udf <= w_set_udf | (r_err_udf & ~bus.fi_err_clr);
        end
    end

    // Wraps to DEPTH-1 when empty, where the output is don't-care anyway.
    assign w_rd_idx = AWIDTH'(r_level - 1'b1);

    assign bus.fo_dat     = r_sh[w_rd_idx];
    assign bus.fo_stb     = ~w_empty;
    assign bus.fi_empty   = w_empty;
    assign bus.fi_full    = w_full;
    assign bus.fi_busy    = (r_level >= BusyThr);
    assign bus.fi_aempty  = (r_level <= AemptyThr);
    assign bus.fi_level   = r_level;
    assign bus.fi_err_ovf = r_err_ovf;
    assign bus.fi_err_udf = r_err_udf;

endmodule

// File: tb/tb_distributed_fifo_shift_lvl.sv
// Scoreboard bench for distributed_fifo_shift_lvl: a queue-based model predicts
// status and popped words; a negedge monitor compares the DUT against it.
module tb_distributed_fifo_shift_lvl;
    localparam int unsigned WIDTH      = 16;
    localparam int unsigned AWIDTH     = 3;
    localparam int unsigned DEPTH      = 8;
    localparam int unsigned BUSY_NUM   = 2;
    localparam int unsigned AEMPTY_NUM = 1;

    logic fi_clk = 1'b0;
    logic fi_rst_n = 1'b0;
    always #5 fi_clk = ~fi_clk;

    distributed_fifo_shift_lvl_if #(.WIDTH(WIDTH), .AWIDTH(AWIDTH)) bus ();

    distributed_fifo_shift_lvl #(
        .WIDTH      (WIDTH),
        .AWIDTH     (AWIDTH),
        .BUSY_NUM   (BUSY_NUM),
        .AEMPTY_NUM (AEMPTY_NUM)
    ) dut (
        .fi_clk   (fi_clk),
        .fi_rst_n (fi_rst_n),
        .bus      (bus)
    );

    // Reference model: contents as a queue (front = oldest) plus the flags.
    logic [WIDTH-1:0] m_q[$];
    bit               m_ovf;
    bit               m_udf;
    logic [WIDTH-1:0] exp_q[$];
    int               n_vec = 0;
    int               n_err = 0;
    bit               mon_en = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compare DUT state against the model each cycle, and score pops.
    always @(negedge fi_clk) begin
        int lvl;
        if (mon_en) begin
            lvl = m_q.size();
            check("level",  32'(bus.fi_level), 32'(lvl));
            check("empty",  32'(bus.fi_empty), 32'(lvl == 0));
            check("full",   32'(bus.fi_full), 32'(lvl == int'(DEPTH)));
            check("busy",   32'(bus.fi_busy), 32'(lvl >= int'(DEPTH - BUSY_NUM)));
            check("aempty", 32'(bus.fi_aempty), 32'(lvl <= int'(AEMPTY_NUM)));
            check("fo_stb", 32'(bus.fo_stb), 32'(lvl != 0));
            check("err_ovf", 32'(bus.fi_err_ovf), 32'(m_ovf));
            check("err_udf", 32'(bus.fi_err_udf), 32'(m_udf));
            if (lvl != 0) check("fo_dat_head", 32'(bus.fo_dat), 32'(m_q[0]));
            if (fi_rst_n && !bus.fi_flush && bus.fo_stb && bus.fo_ack) begin
                check("pop_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("pop_dat", 32'(bus.fo_dat), 32'(exp_q.pop_front()));
            end
        end
    end

    // Drive one cycle of inputs, predict the outcome, advance past the edge.
    task automatic step(bit rst_n, bit stb, logic [WIDTH-1:0] dat, bit ack, bit flush, bit clr);
        logic [WIDTH-1:0] nq[$];
        bit novf, nudf, pop, push, full;
        fi_rst_n       = rst_n;
        bus.fi_stb     = stb;
        bus.fi_dat     = dat;
        bus.fo_ack     = ack;
        bus.fi_flush   = flush;
        bus.fi_err_clr = clr;
        nq = m_q;
        if (!rst_n) begin
            nq.delete();
            novf = 1'b0;
            nudf = 1'b0;
        end else if (flush) begin
            nq.delete();
            novf = m_ovf && !clr;
            nudf = m_udf && !clr;
        end else begin
            full = (m_q.size() == int'(DEPTH));
            pop  = ack && (m_q.size() != 0);
            push = stb && (!full || pop);
            novf = (stb && full && !pop) || (m_ovf && !clr);
            nudf = (ack && m_q.size() == 0) || (m_udf && !clr);
            if (pop) exp_q.push_back(nq.pop_front());
            if (push) nq.push_back(dat);
        end
        @(posedge fi_clk);
        #1;
        m_q   = nq;
        m_ovf = novf;
        m_udf = nudf;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.fi_stb = 1'b0; bus.fi_dat = '0; bus.fo_ack = 1'b0;
        bus.fi_flush = 1'b0; bus.fi_err_clr = 1'b0;
        @(posedge fi_clk);
        #1;
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;
        idle();

        // Fill 1..8, overflow attempt, then drain.
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h00AA, 1'b0, 1'b0, 1'b0);
        idle();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Simultaneous push/pop while full, then drain.
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h0009, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Underflow, clear colliding with a new set, then a plain clear.
        step(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle();

        // Push/pop at level 1 together, then flush at level 5 with push and ack.
        step(1'b1, 1'b1, 16'h0055, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h0066, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 16'(16'h0100 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h0BAD, 1'b1, 1'b1, 1'b0);
        idle();

        // Reset mid-stream at level 4, then a fresh word.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 16'(16'h0200 + i), 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle();

        // Random traffic with phases biased toward filling and draining.
        for (int i = 0; i < 800; i++) begin
            int unsigned stb_pct;
            int unsigned ack_pct;
            stb_pct = ((i / 100) % 2 == 0) ? 75 : 35;
            ack_pct = ((i / 100) % 2 == 0) ? 35 : 75;
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 99) < stb_pct),
                 16'($urandom),
                 ($urandom_range(0, 99) < ack_pct),
                 ($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 99) < 5));
        end

        idle();
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
